// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter and its byte-lane formatter.
package mem_port_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY_IF = 2'b01,
    BUSY_D  = 2'b10,
    RESP    = 2'b11
  } state_e;

  localparam int TIMEOUT_CYCLES_DEF = 255;

  // A D request that can never reach memory: illegal size or a misaligned half/word.
  function automatic logic d_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == SZ_ILL) ||
           ((size == SZ_HALF) && lo[0]) ||
           ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around the arbiter.
// slave = arbiter view, master = pipeline + memory environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [1:0]        d_size;
  logic              d_signed;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_size, d_signed, d_wdata,
           mem_ack, mem_rdata,
    output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_size, d_signed, d_wdata,
           mem_ack, mem_rdata,
    input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_lsu_lane_fmt.sv
// Combinational byte-lane formatter: byte enables, store-lane replication and
// load extraction with sign/zero extension.
module lsu_lane_fmt
  import mem_port_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte = rdata_in[7:0];
    case (addr_lo)
      2'd0:    rd_byte = rdata_in[7:0];
      2'd1:    rd_byte = rdata_in[15:8];
      2'd2:    rd_byte = rdata_in[23:16];
      default: rd_byte = rdata_in[31:24];
    endcase
    rd_half = addr_lo[1] ? rdata_in[31:16] : rdata_in[15:0];

    be        = 4'b0000;
    wdata_out = wdata_in;
    rdata_out = rdata_in;
    case (size)
      SZ_WORD: be = 4'b1111;
      SZ_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_out = {2{wdata_in[15:0]}};
        rdata_out = {{16{is_signed & rd_half[15]}}, rd_half};
      end
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_out = {4{wdata_in[7:0]}};
        rdata_out = {{24{is_signed & rd_byte[7]}}, rd_byte};
      end
      default: begin
        be        = 4'b0000;
        wdata_out = 32'h0;
        rdata_out = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the shared data-memory port (D beats IF).
// Optional MEM_TIMEOUT_EN: abort a memory access that is not acked in TIMEOUT_CYCLES.
module mem_port_arbiter
  import mem_port_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);

  state_e state, state_nxt;

  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;
  logic              resp_is_d, resp_err;
  logic [31:0]       resp_rdata;
  logic [1:0]        cur_lo, cur_size;
  logic              cur_signed;

  logic        d_bad, if_bad, busy, tmo_hit;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_rdata;
  logic [31:0] unused_st_rdata, unused_ld_wdata;
  logic [3:0]  unused_ld_be;

  assign d_bad  = d_misaligned(bus.d_size, bus.d_addr[1:0]);
  assign if_bad = (bus.if_addr[1:0] != 2'b00);
  assign busy   = (state == BUSY_IF) || (state == BUSY_D);

  // Store path uses the live request; load path uses the fields latched at grant.
  lsu_lane_fmt u_store_fmt (
    .addr_lo   (bus.d_addr[1:0]),
    .size      (bus.d_size),
    .is_signed (bus.d_signed),
    .wdata_in  (bus.d_wdata),
    .rdata_in  (bus.mem_rdata),
    .be        (st_be),
    .wdata_out (st_wdata),
    .rdata_out (unused_st_rdata)
  );

  lsu_lane_fmt u_load_fmt (
    .addr_lo   (cur_lo),
    .size      (cur_size),
    .is_signed (cur_signed),
    .wdata_in  (32'h0),
    .rdata_in  (bus.mem_rdata),
    .be        (unused_ld_be),
    .wdata_out (unused_ld_wdata),
    .rdata_out (ld_rdata)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst)       tmo_cnt <= '0;
    else if (busy) tmo_cnt <= tmo_cnt + 1'b1;
    else           tmo_cnt <= '0;
  end

  assign tmo_hit = busy && !bus.mem_ack && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.d_req)       state_nxt = d_bad  ? RESP : BUSY_D;
        else if (bus.if_req) state_nxt = if_bad ? RESP : BUSY_IF;
      end
      BUSY_IF, BUSY_D: begin
        if (bus.mem_ack || tmo_hit) state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.if_ack   = 1'b0;
    bus.if_rdata = 32'h0;
    bus.if_err   = 1'b0;
    bus.d_ack    = 1'b0;
    bus.d_rdata  = 32'h0;
    bus.d_err    = 1'b0;
    if (state == RESP) begin
      if (resp_is_d) begin
        bus.d_ack   = 1'b1;
        bus.d_rdata = resp_rdata;
        bus.d_err   = resp_err;
      end else begin
        bus.if_ack   = 1'b1;
        bus.if_rdata = resp_rdata;
        bus.if_err   = resp_err;
      end
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Memory-port registers and the response latched for the RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      resp_is_d   <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= 32'h0;
      cur_lo      <= 2'b00;
      cur_size    <= 2'b00;
      cur_signed  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.d_req) begin
            resp_is_d  <= 1'b1;
            resp_err   <= d_bad;
            resp_rdata <= 32'h0;
            cur_lo     <= bus.d_addr[1:0];
            cur_size   <= bus.d_size;
            cur_signed <= bus.d_signed;
            if (!d_bad) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.d_we;
              mem_addr_q  <= {bus.d_addr[ADDR_W-1:2], 2'b00};
              mem_be_q    <= st_be;
              mem_wdata_q <= st_wdata;
            end
          end else if (bus.if_req) begin
            resp_is_d  <= 1'b0;
            resp_err   <= if_bad;
            resp_rdata <= 32'h0;
            if (!if_bad) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= {bus.if_addr[ADDR_W-1:2], 2'b00};
              mem_be_q    <= 4'b1111;
              mem_wdata_q <= 32'h0;
            end
          end
        end
        BUSY_IF, BUSY_D: begin
          if (bus.mem_ack || tmo_hit) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
            if (bus.mem_ack) begin
              resp_err   <= 1'b0;
              resp_rdata <= (state == BUSY_D) ? ld_rdata : bus.mem_rdata;
            end else begin
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a small delayed-ack memory model.
// Define MEM_TIMEOUT_EN to build the DUT with a 4-cycle timeout and run the timeout sequence.
module tb_mem_port_arbiter;
  import mem_port_pkg::*;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory model: acks mem_delay cycles after mem_req rises, or injects acks when muted.
  int          mem_delay   = 2;
  int          mem_cnt     = 0;
  logic [31:0] mem_word    = 32'h0;
  bit          mem_mute    = 1'b0;
  bit          inject_ack  = 1'b0;

  always @(negedge clk) begin
    if (mem_mute) begin
      bus.mem_ack   = inject_ack;
      bus.mem_rdata = inject_ack ? 32'hCAFE_F00D : 32'h0;
      mem_cnt       = 0;
    end else begin
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        mem_cnt++;
        if (mem_cnt == mem_delay + 1) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_word;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic        exp_mem;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string what, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s #%0d: got %h expected %h", what, idx, act, exp);
    end
  endtask

  // One D request; returns what was seen on the memory port and at d_ack.
  task automatic applyStimulus(input vec_t v, output int ack_cyc, output logic seen,
                               output logic [31:0] o_maddr, output logic [3:0] o_be,
                               output logic o_we, output logic [31:0] o_wdata,
                               output logic [31:0] o_rdata, output logic o_err);
    int cyc = 0;
    ack_cyc = -1; seen = 1'b0; o_maddr = '0; o_be = '0; o_we = 1'b0;
    o_wdata = '0; o_rdata = '0; o_err = 1'b0;
    @(negedge clk);
    mem_word     = v.mrdata;
    bus.d_we     = v.we;
    bus.d_addr   = v.addr;
    bus.d_size   = v.size;
    bus.d_signed = v.sgn;
    bus.d_wdata  = v.wdata;
    bus.d_req    = 1'b1;
    if (bus.d_ack) ack_cyc = 0;
    while (ack_cyc < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_req && !seen) begin
        seen = 1'b1; o_maddr = bus.mem_addr; o_be = bus.mem_be;
        o_we = bus.mem_we; o_wdata = bus.mem_wdata;
      end
      if (bus.d_ack) begin
        ack_cyc = cyc; o_rdata = bus.d_rdata; o_err = bus.d_err;
      end
    end
    bus.d_req = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input int idx);
    int ack_cyc; logic seen, o_we, o_err;
    logic [31:0] o_maddr, o_wdata, o_rdata; logic [3:0] o_be;
    applyStimulus(v, ack_cyc, seen, o_maddr, o_be, o_we, o_wdata, o_rdata, o_err);
    checkOutput("ack_cycle", idx, 32'(ack_cyc), 32'(v.exp_cyc));
    checkOutput("mem_req_seen", idx, {31'h0, seen}, {31'h0, v.exp_mem});
    checkOutput("d_err", idx, {31'h0, o_err}, {31'h0, v.exp_err});
    if (v.exp_mem) begin
      checkOutput("mem_addr", idx, o_maddr, v.exp_maddr);
      checkOutput("mem_be", idx, {28'h0, o_be}, {28'h0, v.exp_be});
      checkOutput("mem_we", idx, {31'h0, o_we}, {31'h0, v.we});
      if (v.we) checkOutput("mem_wdata", idx, o_wdata, v.exp_wdata);
    end
    if (v.chk_rdata) checkOutput("d_rdata", idx, o_rdata, v.exp_rdata);
  endtask

  initial begin
    int cyc, d_cyc, i_cyc, n_rise, hi_cnt;
    logic prev, i_err, quiet, seen;
    logic [31:0] d_rd, i_rd, rise_addr[2];
    int rise_cyc[2];
    vec_t v;

    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
    bus.d_size = '0; bus.d_signed = 0; bus.d_wdata = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;

    // we, addr, size, sgn, wdata, mrdata | exp_mem, maddr, be, wdata, chk_rd, rdata, err, cyc
    vecs[0]  = '{1'b0, 32'h1003, SZ_BYTE, 1'b1, 32'h0, 32'h80FF_1234, 1'b1, 32'h1000, 4'b1000, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, 4};
    vecs[1]  = '{1'b0, 32'h2002, SZ_HALF, 1'b0, 32'h0, 32'h9ABC_0000, 1'b1, 32'h2000, 4'b1100, 32'h0, 1'b1, 32'h0000_9ABC, 1'b0, 4};
    vecs[2]  = '{1'b1, 32'h2002, SZ_HALF, 1'b0, 32'h1111_BEEF, 32'h0, 1'b1, 32'h2000, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0, 1'b0, 4};
    vecs[3]  = '{1'b0, 32'h0100, SZ_WORD, 1'b0, 32'h0, 32'h1234_5678, 1'b1, 32'h0100, 4'b1111, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 4};
    vecs[4]  = '{1'b0, 32'h0001, SZ_BYTE, 1'b0, 32'h0, 32'h0000_AB00, 1'b1, 32'h0000, 4'b0010, 32'h0, 1'b1, 32'h0000_00AB, 1'b0, 4};
    vecs[5]  = '{1'b0, 32'h0000, SZ_HALF, 1'b1, 32'h0, 32'h0000_8001, 1'b1, 32'h0000, 4'b0011, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0, 4};
    vecs[6]  = '{1'b1, 32'h0002, SZ_BYTE, 1'b0, 32'h0000_00A5, 32'h0, 1'b1, 32'h0000, 4'b0100, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0, 4};
    vecs[7]  = '{1'b1, 32'h0004, SZ_WORD, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1, 32'h0004, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 4};
    vecs[8]  = '{1'b0, 32'h0006, SZ_WORD, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0, 1'b1, 1};
    vecs[9]  = '{1'b0, 32'h0008, SZ_ILL,  1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0, 1'b1, 1};
    vecs[10] = '{1'b0, 32'h0003, SZ_HALF, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0, 1'b1, 1};
    vecs[11] = '{1'b0, 32'h0002, SZ_BYTE, 1'b1, 32'h0, 32'h00FF_0000, 1'b1, 32'h0000, 4'b0100, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 4};

    repeat (3) @(negedge clk);
    checkOutput("rst_mem_ctl", 0, {27'h0, bus.mem_req, bus.mem_we, bus.mem_be}, 32'h0);
    checkOutput("rst_mem_addr", 0, bus.mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", 0, bus.mem_wdata, 32'h0);
    checkOutput("rst_acks", 0, {28'h0, bus.d_ack, bus.if_ack, bus.d_err, bus.if_err}, 32'h0);
    checkOutput("rst_rdata", 0, bus.d_rdata | bus.if_rdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) runVector(vecs[i], i);

    // Simultaneous IF and D: D first, IF re-arbitrated after the RESP/IDLE pair.
    mem_word = 32'h1111_2222;
    @(negedge clk);
    bus.if_addr = 32'h0040; bus.if_req = 1'b1;
    bus.d_addr = 32'h0100; bus.d_size = SZ_WORD; bus.d_we = 1'b0; bus.d_signed = 1'b0; bus.d_req = 1'b1;
    cyc = 0; d_cyc = -1; i_cyc = -1; n_rise = 0; prev = 1'b0;
    d_rd = '0; i_rd = '0; i_err = 1'b1; rise_cyc[0] = -1; rise_cyc[1] = -1;
    rise_addr[0] = '0; rise_addr[1] = '0;
    while (i_cyc < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_req && !prev) begin
        if (n_rise < 2) begin rise_cyc[n_rise] = cyc; rise_addr[n_rise] = bus.mem_addr; end
        n_rise++;
      end
      prev = bus.mem_req;
      if (bus.d_ack) begin d_cyc = cyc; d_rd = bus.d_rdata; bus.d_req = 1'b0; mem_word = 32'h3333_4444; end
      if (bus.if_ack) begin i_cyc = cyc; i_rd = bus.if_rdata; i_err = bus.if_err; bus.if_req = 1'b0; end
    end
    checkOutput("sim_d_ack_cycle", 0, 32'(d_cyc), 32'd4);
    checkOutput("sim_d_rdata", 0, d_rd, 32'h1111_2222);
    checkOutput("sim_rise0_cycle", 0, 32'(rise_cyc[0]), 32'd1);
    checkOutput("sim_rise0_addr", 0, rise_addr[0], 32'h0100);
    checkOutput("sim_rise1_cycle", 0, 32'(rise_cyc[1]), 32'd6);
    checkOutput("sim_rise1_addr", 0, rise_addr[1], 32'h0040);
    checkOutput("sim_if_ack_cycle", 0, 32'(i_cyc), 32'd9);
    checkOutput("sim_if_rdata", 0, i_rd, 32'h3333_4444);
    checkOutput("sim_if_err", 0, {31'h0, i_err}, 32'h0);
    checkOutput("sim_rise_count", 0, 32'(n_rise), 32'd2);

    // Misaligned fetch is answered without touching memory.
    @(negedge clk);
    bus.if_addr = 32'h0042; bus.if_req = 1'b1;
    cyc = 0; i_cyc = -1; seen = 1'b0; i_err = 1'b0;
    while (i_cyc < 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_req) seen = 1'b1;
      if (bus.if_ack) begin i_cyc = cyc; i_err = bus.if_err; i_rd = bus.if_rdata; end
    end
    bus.if_req = 1'b0;
    checkOutput("if_bad_ack_cycle", 0, 32'(i_cyc), 32'd1);
    checkOutput("if_bad_err", 0, {31'h0, i_err}, 32'h1);
    checkOutput("if_bad_mem_req", 0, {31'h0, seen}, 32'h0);

    // Reset during BUSY_D, followed by a stray mem_ack.
    @(posedge clk); #1;
    mem_mute = 1'b1; inject_ack = 1'b0;
    @(negedge clk);
    bus.d_addr = 32'h0300; bus.d_size = SZ_WORD; bus.d_we = 1'b0; bus.d_req = 1'b1;
    @(negedge clk);
    checkOutput("busy_mem_req", 0, {31'h0, bus.mem_req}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.d_req = 1'b0; inject_ack = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_mem_req", 0, {31'h0, bus.mem_req}, 32'h0);
    checkOutput("post_rst_d_ack", 0, {31'h0, bus.d_ack}, 32'h0);
    @(posedge clk); #1;
    inject_ack = 1'b0;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.d_ack || bus.if_ack || bus.mem_req) quiet = 1'b0;
    end
    checkOutput("post_rst_quiet", 0, {31'h0, quiet}, 32'h1);
    mem_mute = 1'b0; mem_delay = 1;
    v = vecs[3];
    v.exp_cyc = 3;
    runVector(v, 100);
    mem_delay = 2;

`ifdef MEM_TIMEOUT_EN
    // Memory never answers: abort after TMO cycles, then ignore a late ack.
    @(posedge clk); #1;
    mem_mute = 1'b1; inject_ack = 1'b0;
    @(negedge clk);
    bus.d_addr = 32'h0500; bus.d_size = SZ_WORD; bus.d_we = 1'b0; bus.d_req = 1'b1;
    cyc = 0; d_cyc = -1; hi_cnt = 0; d_rd = 32'hFFFF_FFFF; i_err = 1'b0;
    while (d_cyc < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_req) hi_cnt++;
      if (bus.d_ack) begin d_cyc = cyc; d_rd = bus.d_rdata; i_err = bus.d_err; end
    end
    bus.d_req = 1'b0;
    checkOutput("tmo_mem_req_cycles", 0, 32'(hi_cnt), 32'd4);
    checkOutput("tmo_ack_cycle", 0, 32'(d_cyc), 32'd5);
    checkOutput("tmo_err", 0, {31'h0, i_err}, 32'h1);
    checkOutput("tmo_rdata", 0, d_rd, 32'h0);
    @(posedge clk); #1;
    inject_ack = 1'b1;
    @(posedge clk); #1;
    inject_ack = 1'b0;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.d_ack || bus.if_ack || bus.mem_req) quiet = 1'b0;
    end
    checkOutput("tmo_late_ack_ignored", 0, {31'h0, quiet}, 32'h1);
    mem_mute = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
